// File: rtl/conv_out_ctrl_gen_pkg.sv
// rtl/conv_out_ctrl_gen_pkg.sv - shared types and helpers for the 1-D convolution controller
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_VALID,
    ST_DONE
  } conv_state_t;

  function automatic int conv_n_out(int x_size, int f_size, int stride);
    return (stride > 0) ? (x_size - f_size) / stride + 1 : 1;
  endfunction

  function automatic bit conv_params_ok(int x_size, int f_size, int stride, int n_filt);
    return (f_size >= 2) && (f_size <= x_size) && (stride >= 1) && (n_filt >= 1);
  endfunction

endpackage

// File: rtl/conv_out_ctrl_gen_if.sv
// rtl/conv_out_ctrl_gen_if.sv - start/stream handshake and memory/MAC control bundle
interface conv_out_ctrl_gen_if #(
  parameter int XA_W = 3,
  parameter int FA_W = 2,
  parameter int FB_W = 1
);
  logic            conv_start;
  logic            m_ready_y;
  logic [XA_W-1:0] x_addr;
  logic [FA_W-1:0] f_addr;
  logic [FB_W-1:0] f_bank;
  logic            mem_rd_en;
  logic            clr_accum;
  logic            en_accum;
  logic            m_valid_y;
  logic [FB_W-1:0] y_filt;
  logic            conv_done;

  modport master (
    input  conv_start, m_ready_y,
    output x_addr, f_addr, f_bank, mem_rd_en, clr_accum, en_accum,
           m_valid_y, y_filt, conv_done
  );

  modport slave (
    output conv_start, m_ready_y,
    input  x_addr, f_addr, f_bank, mem_rd_en, clr_accum, en_accum,
           m_valid_y, y_filt, conv_done
  );
endinterface

// File: rtl/conv_out_ctrl_gen_addr.sv
// rtl/conv_out_ctrl_gen_addr.sv - position base, tap and filter counters for the conv controller
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int X_SIZE = 8,
  parameter int F_SIZE = 4,
  parameter int STRIDE = 1,
  parameter int N_FILT = 1,
  parameter int XA_W   = 3,
  parameter int FA_W   = 2,
  parameter int FB_W   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            step,
  input  logic            next,
  output logic [XA_W-1:0] x_addr,
  output logic [FA_W-1:0] f_addr,
  output logic [FB_W-1:0] f_bank,
  output logic            last_tap,
  output logic            last_filt,
  output logic            last_pos
);
  localparam int LAST_BASE = (conv_n_out(X_SIZE, F_SIZE, STRIDE) - 1) * STRIDE;

  // base holds p*STRIDE as a running sum; one spare bit keeps the add from wrapping
  logic [XA_W:0]   base_q, base_d;
  logic [FA_W-1:0] tap_q, tap_d;
  logic [FB_W-1:0] filt_q, filt_d;

  assign last_tap  = (tap_q == FA_W'(F_SIZE - 1));
  assign last_filt = (filt_q == FB_W'(N_FILT - 1));
  assign last_pos  = (base_q == (XA_W + 1)'(LAST_BASE));

  always_comb begin
    base_d = base_q;
    tap_d  = tap_q;
    filt_d = filt_q;
    if (clr) begin
      base_d = '0;
      tap_d  = '0;
      filt_d = '0;
    end else begin
      if (step) tap_d = last_tap ? '0 : tap_q + FA_W'(1);
      if (next) begin
        if (!last_filt) begin
          filt_d = filt_q + FB_W'(1);
        end else begin
          filt_d = '0;
          base_d = last_pos ? '0 : base_q + (XA_W + 1)'(STRIDE);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      tap_q  <= '0;
      filt_q <= '0;
    end else begin
      base_q <= base_d;
      tap_q  <= tap_d;
      filt_q <= filt_d;
    end
  end

  assign x_addr = base_q[XA_W-1:0] + XA_W'(tap_q);
  assign f_addr = tap_q;
  assign f_bank = filt_q;

endmodule

// File: rtl/conv_out_ctrl_gen.sv
// rtl/conv_out_ctrl_gen.sv - strided multi-filter 1-D convolution control FSM
module conv_out_ctrl_gen
  import conv_pkg::*;
#(
  parameter int X_SIZE = 8,
  parameter int F_SIZE = 4,
  parameter int STRIDE = 1,
  parameter int N_FILT = 1,
  parameter int XA_W   = $clog2(X_SIZE),
  parameter int FA_W   = $clog2(F_SIZE),
  parameter int FB_W   = (N_FILT > 1) ? $clog2(N_FILT) : 1
) (
  input logic               clk,
  input logic               reset,
  conv_out_ctrl_gen_if.master bus
);
  if (!conv_params_ok(X_SIZE, F_SIZE, STRIDE, N_FILT)) begin : g_bad_params
    $error("conv_out_ctrl_gen: illegal X_SIZE/F_SIZE/STRIDE/N_FILT");
  end

  conv_state_t     state_q, state_d;
  logic            clr, step, next;
  logic            rd_en, clr_acc, en_acc, valid, done;
  logic [XA_W-1:0] x_addr_i;
  logic [FA_W-1:0] f_addr_i;
  logic [FB_W-1:0] f_bank_i;
  logic            last_tap, last_filt, last_pos;

  conv_addr_gen #(
    .X_SIZE(X_SIZE), .F_SIZE(F_SIZE), .STRIDE(STRIDE), .N_FILT(N_FILT),
    .XA_W(XA_W), .FA_W(FA_W), .FB_W(FB_W)
  ) u_addr (
    .clk(clk), .reset(reset), .clr(clr), .step(step), .next(next),
    .x_addr(x_addr_i), .f_addr(f_addr_i), .f_bank(f_bank_i),
    .last_tap(last_tap), .last_filt(last_filt), .last_pos(last_pos)
  );

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    step    = 1'b0;
    next    = 1'b0;
    rd_en   = 1'b0;
    clr_acc = 1'b0;
    en_acc  = 1'b0;
    valid   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.conv_start) begin
          clr     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en   = 1'b1;
        step    = 1'b1;
        // the accumulate strobe trails the read by one cycle, so tap 0 only clears
        clr_acc = (f_addr_i == '0);
        en_acc  = (f_addr_i != '0);
        if (last_tap) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        en_acc  = 1'b1;
        state_d = ST_VALID;
      end
      ST_VALID: begin
        valid = 1'b1;
        if (bus.m_ready_y) begin
          next    = 1'b1;
          state_d = (last_filt && last_pos) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        clr     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign bus.x_addr    = rd_en ? x_addr_i : '0;
  assign bus.f_addr    = rd_en ? f_addr_i : '0;
  assign bus.f_bank    = rd_en ? f_bank_i : '0;
  assign bus.mem_rd_en = rd_en;
  assign bus.clr_accum = clr_acc;
  assign bus.en_accum  = en_acc;
  assign bus.m_valid_y = valid;
  assign bus.y_filt    = valid ? f_bank_i : '0;
  assign bus.conv_done = done;

endmodule

// File: tb/tb_conv_out_ctrl_gen.sv
// tb/tb_conv_out_ctrl_gen.sv - scoreboard bench for conv_out_ctrl_gen (strided, 3 filter banks)
module tb_conv_out_ctrl_gen;
  localparam int X_SIZE = 10;
  localparam int F_SIZE = 3;
  localparam int STRIDE = 3;
  localparam int N_FILT = 3;
  localparam int XA_W   = $clog2(X_SIZE);
  localparam int FA_W   = $clog2(F_SIZE);
  localparam int FB_W   = $clog2(N_FILT);
  localparam int N_OUT  = (X_SIZE - F_SIZE) / STRIDE + 1;

  typedef struct { int xa; int fa; int fb; bit clr; } rd_t;
  typedef struct { int filt; bit last; } out_t;

  rd_t  rd_q[$];
  out_t out_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_count = 0;
  int   hs_in_frame = 0;
  int   ready_mode = 0;
  int   hold_cnt = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_out_ctrl_gen_if #(.XA_W(XA_W), .FA_W(FA_W), .FB_W(FB_W)) bus ();

  conv_out_ctrl_gen #(
    .X_SIZE(X_SIZE), .F_SIZE(F_SIZE), .STRIDE(STRIDE), .N_FILT(N_FILT),
    .XA_W(XA_W), .FA_W(FA_W), .FB_W(FB_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic fail(string name, int act, int exp);
    miscompares++;
    $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: every output y[p][k] reads taps j of x[p*STRIDE+j] and f[k][j]
  task automatic push_frame();
    for (int p = 0; p < N_OUT; p++) begin
      for (int k = 0; k < N_FILT; k++) begin
        for (int j = 0; j < F_SIZE; j++) begin
          rd_t r;
          r.xa = p * STRIDE + j;
          r.fa = j;
          r.fb = k;
          r.clr = (j == 0);
          rd_q.push_back(r);
        end
        begin
          out_t o;
          o.filt = k;
          o.last = (p == N_OUT - 1) && (k == N_FILT - 1);
          out_q.push_back(o);
        end
      end
    end
  endtask

  task automatic check_idle(string name);
    int act;
    act = int'(bus.x_addr) + int'(bus.f_addr) + int'(bus.f_bank) + int'(bus.y_filt) +
          int'(bus.mem_rd_en) + int'(bus.clr_accum) + int'(bus.en_accum) +
          int'(bus.m_valid_y) + int'(bus.conv_done);
    vectors++;
    if (act != 0) fail(name, act, 0);
  endtask

  task automatic start_frame();
    @(posedge clk); #2;
    push_frame();
    bus.conv_start = 1'b1;
    @(posedge clk); #2;
    bus.conv_start = 1'b0;
  endtask

  task automatic wait_done(int target);
    int n;
    n = 0;
    while (done_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done_count < target) fail("done_timeout", done_count, target);
  endtask

  task automatic wait_read_after(int hs);
    int n;
    n = 0;
    while (!(hs_in_frame >= hs && bus.mem_rd_en) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 3000) fail("run_timeout", hs_in_frame, hs);
  endtask

  initial begin : ready_drv
    bus.m_ready_y = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ready_mode == 0) begin
        bus.m_ready_y = 1'b1;
      end else if (ready_mode == 1) begin
        bus.m_ready_y = 1'($urandom_range(0, 1));
      end else if (bus.m_valid_y && hs_in_frame == 2 && hold_cnt < 5) begin
        bus.m_ready_y = 1'b0;
        hold_cnt++;
      end else begin
        bus.m_ready_y = 1'b1;
      end
    end
  end

  initial begin : monitor
    int   cycle, clr_cycle, last_rise, prev_filt;
    bit   prev_rd, prev_valid, exp_done, exp_done_next;
    rd_t  e;
    out_t o;
    cycle = 0; clr_cycle = 0; last_rise = -1; prev_filt = 0;
    prev_rd = 0; prev_valid = 0; exp_done = 0;
    forever begin
      @(negedge clk);
      cycle++;
      exp_done_next = 0;
      if (reset) begin
        prev_rd = 0; prev_valid = 0; exp_done = 0; last_rise = -1;
      end else begin
        vectors++;
        if (bus.en_accum !== prev_rd) fail("en_lag", int'(bus.en_accum), int'(prev_rd));
        if (bus.mem_rd_en) begin
          vectors++;
          if (rd_q.size() == 0) begin
            fail("unexpected_read", int'(bus.x_addr), -1);
          end else begin
            e = rd_q.pop_front();
            if (int'(bus.x_addr) != e.xa || int'(bus.f_addr) != e.fa ||
                int'(bus.f_bank) != e.fb || bus.clr_accum != e.clr) begin
              miscompares++;
              $display("FAIL read: got x=%0d f=%0d bank=%0d clr=%0d, expected x=%0d f=%0d bank=%0d clr=%0d",
                       bus.x_addr, bus.f_addr, bus.f_bank, bus.clr_accum, e.xa, e.fa, e.fb, e.clr);
            end
            if (e.clr) clr_cycle = cycle;
          end
        end else if (bus.clr_accum) begin
          fail("clr_without_read", 1, 0);
        end
        if (bus.m_valid_y) begin
          vectors++;
          if (bus.mem_rd_en || bus.en_accum)
            fail("valid_quiet", int'(bus.mem_rd_en) * 2 + int'(bus.en_accum), 0);
          if (!prev_valid) begin
            vectors++;
            if (cycle - clr_cycle != F_SIZE + 1) fail("latency", cycle - clr_cycle, F_SIZE + 1);
            if (ready_mode == 0 && last_rise >= 0) begin
              vectors++;
              if (cycle - last_rise != F_SIZE + 2) fail("spacing", cycle - last_rise, F_SIZE + 2);
            end
            last_rise = cycle;
          end else begin
            vectors++;
            if (int'(bus.y_filt) != prev_filt) fail("y_filt_stable", int'(bus.y_filt), prev_filt);
          end
          if (bus.m_ready_y) begin
            vectors++;
            if (out_q.size() == 0) begin
              fail("unexpected_output", int'(bus.y_filt), -1);
            end else begin
              o = out_q.pop_front();
              if (int'(bus.y_filt) != o.filt) fail("y_filt", int'(bus.y_filt), o.filt);
              exp_done_next = o.last;
            end
            hs_in_frame++;
          end
        end
        vectors++;
        if (bus.conv_done !== exp_done) fail("conv_done", int'(bus.conv_done), int'(exp_done));
        if (bus.conv_done) begin
          done_count++;
          hs_in_frame = 0;
          last_rise = -1;
        end
        exp_done   = exp_done_next;
        prev_rd    = bus.mem_rd_en;
        prev_valid = bus.m_valid_y;
        prev_filt  = int'(bus.y_filt);
      end
    end
  end

  initial begin : stim
    int n;
    bus.conv_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset_state");
    reset = 1'b0;

    ready_mode = 0;
    start_frame();
    wait_done(1);

    ready_mode = 1;
    start_frame();
    wait_done(2);

    ready_mode = 2;
    hold_cnt = 0;
    start_frame();
    wait_done(3);

    // conv_start held through DONE: second frame follows straight from IDLE
    ready_mode = 0;
    @(posedge clk); #2;
    push_frame();
    push_frame();
    bus.conv_start = 1'b1;
    wait_done(4);
    n = 0;
    while (!bus.mem_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 20) fail("restart_timeout", n, 20);
    @(posedge clk); #2;
    bus.conv_start = 1'b0;
    wait_done(5);

    // reset in the middle of output 3 aborts the frame silently
    ready_mode = 1;
    start_frame();
    wait_read_after(3);
    @(posedge clk); #2;
    reset = 1'b1;
    rd_q.delete();
    out_q.delete();
    @(posedge clk); #2;
    check_idle("reset_abort");
    reset = 1'b0;
    hs_in_frame = 0;
    repeat (6) @(posedge clk);
    vectors++;
    if (done_count != 5) fail("abort_no_done", done_count, 5);

    ready_mode = 0;
    start_frame();
    wait_done(6);

    repeat (3) @(posedge clk);
    vectors++;
    if (rd_q.size() + out_q.size() != 0) fail("queues_drained", rd_q.size() + out_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_out_ctrl_gen.md
# conv_out_ctrl_gen

Parametrised control block for the 1-D convolution datapath. It generates X/F memory read addresses, MAC accumulator controls and the AXI-stream style output valid. It also pulses `conv_done` at the end of a frame. Compared with the single-filter, stride-1 controller, it adds configurable stride, multiple filter banks (position-major, filter-minor output order) and an explicit FSM with a fixed one-cycle memory read latency. It sits between the X/F memory write controllers and the MAC engine.

## Interface
Parameters:
- `X_SIZE`, default 8: number of input samples in X memory.
- `F_SIZE`, default 4: taps per filter; legal range 2..X_SIZE.
- `STRIDE`, default 1: input step between output positions; legal range ≥1.
- `N_FILT`, default 1: number of filter banks held in F memory.
- `XA_W`, default `$clog2(X_SIZE)`: X address width.
- `FA_W`, default `$clog2(F_SIZE)`: F tap address width.
- `FB_W`, default `max(1,$clog2(N_FILT))`: filter bank index width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `conv_start`  in  1  level; memories loaded, frame may begin; sampled only in IDLE.
- `m_ready_y`  in  1  downstream ready.
- `x_addr`  out  XA_W  X memory read address.
- `f_addr`  out  FA_W  F tap address.
- `f_bank`  out  FB_W  F bank select; equals current filter index.
- `mem_rd_en`  out  1  read strobe for X and F memories.
- `clr_accum`  out  1  clear accumulator at next edge.
- `en_accum`  out  1  accumulate the product of the previous cycle's read.
- `m_valid_y`  out  1  output valid.
- `y_filt`  out  FB_W  filter index of the current output.
- `conv_done`  out  1  one-cycle pulse after the last output handshake.

## Operation
- N_OUT = (X_SIZE−F_SIZE)/STRIDE + 1, using integer division. Total outputs per frame = N_OUT·N_FILT.
- Outputs are ordered position-major: for position p = 0..N_OUT−1, filter k = 0..N_FILT−1, y = Σ_j x[p·STRIDE+j]·f[k][j].
- FSM states: IDLE, RUN, FLUSH, VALID, DONE.
- IDLE: all outputs 0. When `conv_start`=1, move to RUN with p=0, k=0, j=0.
- RUN:
  - `mem_rd_en`=1, `x_addr`=p·STRIDE+j, `f_addr`=j, `f_bank`=k.
  - `clr_accum`=1 when j=0.
  - `en_accum`=1 when j>0.
  - j increments each cycle. After j=F_SIZE−1, move to FLUSH.
- FLUSH: one cycle, `en_accum`=1 for the last tap, `mem_rd_en`=0. Then move to VALID.
- VALID:
  - `m_valid_y`=1, `y_filt`=k, `en_accum`=0, and the accumulator is held.
  - Stay in VALID while `m_ready_y`=0.
  - On handshake (`m_valid_y`&`m_ready_y`): if k<N_FILT−1, set k++ and go to RUN. Otherwise set k=0; if p<N_OUT−1, set p++ and go to RUN; otherwise go to DONE.
- DONE: `conv_done`=1 for exactly one cycle, then IDLE. A new frame starts only if `conv_start` is still 1 while in IDLE.
- Deasserting `conv_start` outside IDLE is ignored; the frame always completes.
- Internal arithmetic: the position base p·STRIDE is maintained as a running sum of XA_W+1 bits, with no multiplier. It never exceeds X_SIZE−F_SIZE.

## Timing
- Reset value of every output is 0; the state goes to IDLE; p, k and j are cleared. Reset mid-frame aborts with no `conv_done`.
- Memory read latency is fixed at 1 cycle. `en_accum` always lags its address by one cycle.
- Per-output latency from RUN entry to `m_valid_y` rising is F_SIZE+1 cycles. With `m_ready_y` held high, throughput is one output per F_SIZE+2 cycles.
- `m_valid_y` never depends combinationally on `m_ready_y`. Once `m_valid_y` is asserted, it and `y_filt` stay stable until the handshake.
- `m_ready_y` asserted while `m_valid_y`=0 has no effect.
- `conv_done` rises the cycle after the final handshake.

## Structure
- Shared package `conv_pkg`: state enum `conv_state_t` and the function `conv_n_out(X_SIZE,F_SIZE,STRIDE)`. The package also holds elaboration checks F_SIZE≤X_SIZE, STRIDE≥1 and N_FILT≥1.
- Sub-module `conv_addr_gen` holds the base, tap and filter counters with wrap logic. It is driven by FSM step/next strobes and outputs last_tap, last_filt and last_pos.

## Test plan
- Defaults (X=8, F=4, S=1, N=1), ready held high → 5 outputs. `x_addr` runs 0..3, 1..4, …, 4..7. `m_valid_y` rises 5 cycles after RUN entry, outputs are spaced 6 cycles apart, and `conv_done` pulses once.
- X=9, F=3, S=3 → 3 outputs with x_addr bases 0, 3, 6. No address ever exceeds 8.
- N_FILT=2, X=8, F=4 → 10 outputs with `y_filt` sequence 0,1,0,1,…. `f_bank` matches `y_filt` during each RUN, and the x base repeats for both filters.
- Backpressure: hold `m_ready_y`=0 for 5 cycles on output 2 → `m_valid_y` and `y_filt` are held, `en_accum`=0 and `mem_rd_en`=0, and the frame resumes correctly once ready returns.
- Assert reset during RUN of output 3 → the cycle after reset, all outputs are 0 and the state is IDLE with no `conv_done`. The next `conv_start` restarts at p=0.
- Hold `conv_start`=1 through DONE → a second frame starts the cycle after IDLE and produces identical address sequences. Dropping `conv_start` mid-frame has no effect.
